// File: rtl/timer_pkg.sv
// Shared Timer register map, control bit positions and ramp engine types.
package timer_pkg;

  localparam int TMR_CTRL_ADDR      = 2;
  localparam int TMR_PRESCALER_ADDR = 3;
  localparam int TMR_CMP_ADDR       = 4;

  localparam int CTRL_RUN_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_STEP,
    ST_FIN
  } ramp_state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/timer_bus_mux.sv
// CPU-priority mux onto the single Timer register port. The engine only gets
// the bus in cycles where the CPU leaves chip select low; eng_grant marks the
// cycle in which an engine write actually lands in the Timer.
module timer_bus_mux #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              cpu_cs,
  input  logic              cpu_write,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_grant,
  output logic              tmr_cs,
  output logic              tmr_write,
  output logic              tmr_read,
  output logic [ADDR_W-1:0] tmr_addr,
  output logic [DATA_W-1:0] tmr_wdata,
  input  logic [DATA_W-1:0] tmr_rdata
);

  assign cpu_rdata = tmr_rdata;
  assign eng_grant = eng_req & ~cpu_cs;

  // Select the bus owner: CPU first, engine write second, otherwise idle.
  always_comb begin
    tmr_cs    = 1'b0;
    tmr_write = 1'b0;
    tmr_read  = 1'b0;
    tmr_addr  = '0;
    tmr_wdata = '0;
    if (cpu_cs) begin
      tmr_cs    = 1'b1;
      tmr_write = cpu_write;
      tmr_read  = cpu_read;
      tmr_addr  = cpu_addr;
      tmr_wdata = cpu_wdata;
    end else if (eng_req) begin
      tmr_cs    = 1'b1;
      tmr_write = 1'b1;
      tmr_addr  = eng_addr;
      tmr_wdata = eng_wdata;
    end
  end

endmodule

// File: rtl/timer_duty_ramp_ctrl.sv
// Ramps the Timer compare register from duty_start to duty_end in fixed steps,
// one step per hold_periods PWM periods, sharing the Timer port with the CPU.
module timer_duty_ramp_ctrl
  import timer_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int CTRL_ADDR = TMR_CTRL_ADDR,
  parameter int CMP_ADDR  = TMR_CMP_ADDR,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic              cpu_write,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              tmr_cs,
  output logic              tmr_write,
  output logic              tmr_read,
  output logic [ADDR_W-1:0] tmr_addr,
  output logic [DATA_W-1:0] tmr_wdata,
  input  logic [DATA_W-1:0] tmr_rdata,
  input  logic              period_tick,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] duty_start,
  input  logic [DATA_W-1:0] duty_end,
  input  logic [DATA_W-1:0] duty_step,
  input  logic [CNT_W-1:0]  hold_periods,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] RUN_WORD = DATA_W'(1) << CTRL_RUN_BIT;

  ramp_state_t       state;
  dir_t              dir;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] step;
  logic [CNT_W-1:0]  hold;
  logic [CNT_W-1:0]  cnt;

  logic              eng_req;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_grant;
  logic [DATA_W-1:0] step_next;

  logic              req_up;
  logic [DATA_W-1:0] req_span;
  logic [DATA_W-1:0] step_eff;
  logic [CNT_W-1:0]  hold_eff;

  // Next compare value: one extra bit catches wrap, result clamped to target.
  function automatic logic [DATA_W-1:0] step_clamp(
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] t,
    input logic [DATA_W-1:0] s,
    input dir_t              d
  );
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] r;
    if (d == DIR_UP) begin
      wide = {1'b0, c} + {1'b0, s};
      r    = (wide >= {1'b0, t}) ? t : wide[DATA_W-1:0];
    end else begin
      wide = {1'b0, c} - {1'b0, s};
      r    = (wide[DATA_W] || (wide[DATA_W-1:0] <= t)) ? t : wide[DATA_W-1:0];
    end
    return r;
  endfunction

  assign req_up    = (duty_end >= duty_start);
  assign req_span  = req_up ? (duty_end - duty_start) : (duty_start - duty_end);
  assign step_eff  = (duty_step == '0) ? req_span : duty_step;
  assign hold_eff  = (hold_periods == '0) ? CNT_W'(1) : hold_periods;
  assign step_next = step_clamp(cur, target, step, dir);

  // Engine write request, address and data decoded from the current state.
  always_comb begin
    eng_req   = 1'b0;
    eng_addr  = '0;
    eng_wdata = '0;
    case (state)
      ST_HALT: begin
        eng_req  = 1'b1;
        eng_addr = ADDR_W'(CTRL_ADDR);
      end
      ST_LOAD: begin
        eng_req   = 1'b1;
        eng_addr  = ADDR_W'(CMP_ADDR);
        eng_wdata = cur;
      end
      ST_RUN: begin
        eng_req   = 1'b1;
        eng_addr  = ADDR_W'(CTRL_ADDR);
        eng_wdata = RUN_WORD;
      end
      ST_STEP: begin
        eng_req   = 1'b1;
        eng_addr  = ADDR_W'(CMP_ADDR);
        eng_wdata = step_next;
      end
      default: ;
    endcase
  end

  timer_bus_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .cpu_cs   (cpu_cs),
    .cpu_write(cpu_write),
    .cpu_read (cpu_read),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .eng_req  (eng_req),
    .eng_addr (eng_addr),
    .eng_wdata(eng_wdata),
    .eng_grant(eng_grant),
    .tmr_cs   (tmr_cs),
    .tmr_write(tmr_write),
    .tmr_read (tmr_read),
    .tmr_addr (tmr_addr),
    .tmr_wdata(tmr_wdata),
    .tmr_rdata(tmr_rdata)
  );

  // Ramp sequencer; write states advance only on a granted bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      dir    <= DIR_UP;
      cur    <= '0;
      target <= '0;
      step   <= '0;
      hold   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              cur    <= duty_start;
              target <= duty_end;
              step   <= step_eff;
              hold   <= hold_eff;
              dir    <= req_up ? DIR_UP : DIR_DOWN;
              busy   <= 1'b1;
              state  <= ST_HALT;
            end
          end
          ST_HALT: if (eng_grant) state <= ST_LOAD;
          ST_LOAD: if (eng_grant) state <= ST_RUN;
          ST_RUN: begin
            if (eng_grant) begin
              if (cur == target) begin
                state <= ST_FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_WAIT;
                cnt   <= hold;
              end
            end
          end
          ST_WAIT: begin
            if (period_tick) begin
              if (cnt == CNT_W'(1)) state <= ST_STEP;
              else                  cnt   <= cnt - 1'b1;
            end
          end
          ST_STEP: begin
            if (eng_grant) begin
              cur <= step_next;
              if (step_next == target) begin
                state <= ST_FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_WAIT;
                cnt   <= hold;
              end
            end
          end
          ST_FIN: state <= ST_IDLE;
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_duty_ramp_ctrl.sv
// Bench for timer_duty_ramp_ctrl: directed ramps plus randomized ramps with
// random CPU contention, compared against a per-ramp list of expected writes.
module tb_timer_duty_ramp_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int CTRL_A = 2;
  localparam int CMP_A  = 4;

  typedef logic [ADDR_W+DATA_W-1:0] wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_cs, cpu_write, cpu_read;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              tmr_cs, tmr_write, tmr_read;
  logic [ADDR_W-1:0] tmr_addr;
  logic [DATA_W-1:0] tmr_wdata, tmr_rdata;
  logic              period_tick, start, abort, busy, done;
  logic [DATA_W-1:0] duty_start, duty_end, duty_step;
  logic [CNT_W-1:0]  hold_periods;

  // background generators and manual overrides
  logic              gen_cs = 0, gen_wr = 0, gen_rd = 0, gen_tick = 0;
  logic [ADDR_W-1:0] gen_addr = '0;
  logic [DATA_W-1:0] gen_wdata = '0;
  logic              man_cs = 0, man_rd = 0, man_tick = 0;
  logic [ADDR_W-1:0] man_addr = '0;
  int                tick_period = 0;
  bit                cont_en = 0;

  assign cpu_cs      = gen_cs | man_cs;
  assign cpu_write   = man_cs ? 1'b0 : gen_wr;
  assign cpu_read    = man_cs ? man_rd : gen_rd;
  assign cpu_addr    = man_cs ? man_addr : gen_addr;
  assign cpu_wdata   = man_cs ? '0 : gen_wdata;
  assign period_tick = gen_tick | man_tick;

  // monitor state (written only by the monitor)
  wr_t got[$];
  int  got_ticks[$];
  int  tick_acc = 0;
  int  done_cnt = 0;
  int  mux_n = 0, mux_err = 0;

  // expected writes (written only by main)
  wr_t exp_w[$];
  int  n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  timer_duty_ramp_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .tmr_cs(tmr_cs), .tmr_write(tmr_write), .tmr_read(tmr_read),
    .tmr_addr(tmr_addr), .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata),
    .period_tick(period_tick), .start(start), .abort(abort),
    .duty_start(duty_start), .duty_end(duty_end), .duty_step(duty_step),
    .hold_periods(hold_periods), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // background ticks, CPU contention and Timer read data
  initial begin
    int tc = 0;
    tmr_rdata = '0;
    forever begin
      @(posedge clk); #1;
      tmr_rdata = $urandom;
      gen_tick  = 1'b0;
      if (tick_period > 0) begin
        tc++;
        if (tc >= tick_period) begin
          gen_tick = 1'b1;
          tc = 0;
        end
      end
      if (cont_en && ($urandom_range(0, 3) == 0)) begin
        gen_cs    = 1'b1;
        gen_rd    = 1'($urandom_range(0, 1));
        gen_wr    = ~gen_rd;
        gen_addr  = ADDR_W'($urandom);
        gen_wdata = $urandom;
      end else begin
        gen_cs = 1'b0;
        gen_rd = 1'b0;
        gen_wr = 1'b0;
      end
    end
  end

  // bus observer: engine writes, tick spacing, CPU pass-through, done pulses
  always @(negedge clk) begin
    if (tmr_cs && tmr_write && !cpu_cs) begin
      got.push_back({tmr_addr, tmr_wdata});
      got_ticks.push_back(tick_acc);
      tick_acc <= 0;
    end else if (period_tick) begin
      tick_acc <= tick_acc + 1;
    end
    if (cpu_cs) begin
      mux_n <= mux_n + 1;
      if ({tmr_cs, tmr_write, tmr_read, tmr_addr, tmr_wdata} !==
          {1'b1, cpu_write, cpu_read, cpu_addr, cpu_wdata} || cpu_rdata !== tmr_rdata)
        mux_err <= mux_err + 1;
    end else if (tmr_read) begin
      mux_err <= mux_err + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic sample();
    @(negedge clk); #1;
  endtask

  // reference: the full list of Timer writes a ramp must produce
  task automatic model(input longint s, input longint e, input longint st);
    longint v, stp;
    exp_w.delete();
    exp_w.push_back({ADDR_W'(CTRL_A), 32'd0});
    exp_w.push_back({ADDR_W'(CMP_A), 32'(s)});
    exp_w.push_back({ADDR_W'(CTRL_A), 32'd1});
    stp = (st == 0) ? ((e >= s) ? e - s : s - e) : st;
    v = s;
    while (v != e) begin
      if (e >= s) v = (v + stp > e) ? e : v + stp;
      else        v = (v - stp < e) ? e : v - stp;
      exp_w.push_back({ADDR_W'(CMP_A), 32'(v)});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_ramp(input string tag, input int s, input int e, input int st,
                          input int h, input bit cont_load, input bit chk_ticks);
    int base, dbase, budget, heff;
    model(s, e, st);
    heff  = (h == 0) ? 1 : h;
    base  = got.size();
    dbase = done_cnt;
    duty_start = s; duty_end = e; duty_step = st; hold_periods = CNT_W'(h);
    pulse_start();
    if (!cont_en) begin
      sample();
      chk({tag, "_lat"}, got.size() - base, 1);
      chk({tag, "_busy"}, busy, 1);
    end
    if (cont_load) begin
      @(posedge clk); #1;
      man_cs = 1'b1; man_rd = 1'b1; man_addr = '0;
      for (int i = 0; i < 5; i++) begin
        sample();
        chk({tag, "_stall"}, got.size() - base, 1);
        chk({tag, "_cpuaddr"}, {tmr_cs, tmr_read, tmr_write, tmr_addr}, {3'b110, 5'd0});
        @(posedge clk); #1;
      end
      man_cs = 1'b0; man_rd = 1'b0;
      sample();
      chk({tag, "_resume"}, got.size() - base, 2);
    end
    budget = 0;
    while (done_cnt == dbase && budget < 20000) begin
      sample();
      budget++;
    end
    if (budget >= 20000) chk({tag, "_timeout"}, 0, 1);
    cont_en = 0;
    repeat (3) sample();
    chk({tag, "_nwr"}, got.size() - base, exp_w.size());
    for (int i = 0; i < exp_w.size() && base + i < got.size(); i++) begin
      chk($sformatf("%s_wr%0d", tag, i), got[base+i], exp_w[i]);
      if (chk_ticks && i >= 3)
        chk($sformatf("%s_tk%0d", tag, i), got_ticks[base+i], heff);
    end
    chk({tag, "_done"}, done_cnt - dbase, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int base, dbase, budget;
    rst = 1'b1; start = 0; abort = 0;
    duty_start = '0; duty_end = '0; duty_step = '0; hold_periods = '0;
    man_cs = 1'b1; man_rd = 1'b1; man_addr = 5'd7;
    repeat (3) sample();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mux", {tmr_cs, tmr_read, tmr_addr}, {2'b11, 5'd7});
    man_cs = 0; man_rd = 0;
    @(posedge clk); #1 rst = 1'b0;
    sample();
    chk("idle_bus", {tmr_cs, tmr_write}, 2'b00);

    tick_period = 10;
    run_ramp("up", 2, 8, 2, 1, 0, 1);
    run_ramp("down", 10, 1, 4, 2, 0, 1);
    run_ramp("cont", 2, 8, 2, 1, 1, 1);
    run_ramp("same", 5, 5, 3, 1, 0, 1);
    run_ramp("step0", 3, 9, 0, 2, 0, 1);
    run_ramp("hold0", 7, 4, 1, 0, 0, 1);

    // abort in WAIT after CMP=4; a start while busy must be ignored
    model(2, 8, 2);
    base = got.size(); dbase = done_cnt;
    duty_start = 2; duty_end = 8; duty_step = 2; hold_periods = 1;
    pulse_start();
    budget = 0;
    while (got.size() - base < 3 && budget < 500) begin sample(); budget++; end
    duty_start = 30; duty_end = 31;
    pulse_start();
    while (got.size() - base < 4 && budget < 500) begin sample(); budget++; end
    if (budget >= 500) chk("abort_timeout", 0, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    sample();
    chk("abort_busy", busy, 0);
    repeat (60) sample();
    chk("abort_nwr", got.size() - base, 4);
    for (int i = 0; i < 4 && base + i < got.size(); i++)
      chk($sformatf("abort_wr%0d", i), got[base+i], exp_w[i]);
    chk("abort_done", done_cnt - dbase, 0);

    // reset while STEP is stalled by the CPU
    tick_period = 0;
    base = got.size(); dbase = done_cnt;
    duty_start = 0; duty_end = 20; duty_step = 5; hold_periods = 1;
    pulse_start();
    budget = 0;
    while (got.size() - base < 3 && budget < 100) begin sample(); budget++; end
    @(posedge clk); #1 man_cs = 1'b1; man_rd = 1'b1; man_tick = 1'b1;
    @(posedge clk); #1 man_tick = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sample();
    chk("rstmid_busy", busy, 0);
    man_cs = 1'b0; man_rd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1 man_tick = (i % 4 == 0);
    end
    man_tick = 1'b0;
    sample();
    chk("rstmid_nwr", got.size() - base, 3);
    chk("rstmid_done", done_cnt - dbase, 0);

    // randomized ramps, some with CPU contention
    for (int r = 0; r < 20; r++) begin
      tick_period = $urandom_range(2, 6);
      cont_en = 1'($urandom_range(0, 1));
      run_ramp($sformatf("rnd%0d", r), $urandom_range(0, 40), $urandom_range(0, 40),
               $urandom_range(0, 7), $urandom_range(0, 3), 0, !cont_en);
    end

    sample();
    chk("mux_seen", mux_n > 0, 1);
    chk("mux_pass", mux_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
